product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 16, giving the accumulator width in bits (legal range 13..32).
REQ-002 SHALL have parameter MAX_TERMS, default 15, giving the product count that forces frame close (legal range 1..255).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  a product beat is offered.
REQ-006 SHALL have port in_ready  output  1  the block accepts a beat this cycle.
REQ-007 SHALL have port in_prod  input  12  two's-complement product Z from the upstream 8x4 carry-save array multiplier.
REQ-008 SHALL have port in_last  input  1  marks the final product of the current frame.
REQ-009 SHALL have port out_valid  output  1  the frame result is held on the outputs.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 SHALL have port out_acc  output  ACC_W  saturated two's-complement frame sum.
REQ-012 SHALL have port out_ovf  output  1  sticky flag: saturation occurred during the frame.
REQ-013 SHALL have port out_count  output  8  number of products accumulated in the frame.

Function
REQ-014 SHALL implement the states IDLE, ACCUM and DONE.
REQ-015 SHALL hold in_ready=1 in IDLE and ACCUM, and in_ready=0 in DONE.
REQ-016 SHALL hold out_valid=1 only in DONE; out_acc, out_ovf and out_count SHALL stay stable while out_valid=1.
REQ-017 SHALL accept a beat on a cycle with in_valid=1 and in_ready=1.
REQ-018 SHALL, on a beat accepted in IDLE, load acc=sext(in_prod), count=1, ovf=0, and move to ACCUM.
REQ-019 SHALL, on a beat accepted in ACCUM, set acc=sat(acc+sext(in_prod)) and count=count+1.
REQ-020 SHALL, when the sum leaves the range [-2^(ACC_W-1), 2^(ACC_W-1)-1], clamp it to the nearer bound and set ovf=1; ovf stays set until the next frame starts.
REQ-021 SHALL compute the sum at ACC_W+1 bits to detect overflow; no wrap-around is permitted.
REQ-022 SHALL move to DONE on the edge that accepts a beat with in_last=1, or the beat that brings count to MAX_TERMS, from either IDLE or ACCUM.
REQ-023 SHALL have a latency of 1 cycle: out_valid rises on the cycle after the closing beat is accepted.
REQ-024 SHALL, in DONE with out_ready=1, return to IDLE on that edge; in_ready=1 on the next cycle, so there is one bubble between frames.
REQ-025 SHALL, in DONE, ignore in_valid and in_last; no beat is consumed.
REQ-026 SHALL leave acc and count unchanged in IDLE or ACCUM when in_valid=0.
REQ-027 SHALL, when MAX_TERMS=1, close every frame on its first beat.
REQ-028 SHALL drive out_acc, out_ovf and out_count directly from registers; there is no combinational path from in_* to out_*.

Reset
REQ-029 SHALL, while rst_n=0, force the state to IDLE, acc=0, count=0, ovf=0, out_valid=0 and in_ready=0, asynchronously.
REQ-030 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-031 SHALL, when reset is asserted mid-frame or in DONE, discard the partial or pending result with no output beat.

Verification
REQ-032 SHALL cover a basic frame: beats 5, -3, 100 (last) -> out_acc=102, out_count=3, out_ovf=0; out_valid 1 cycle after the last beat.
REQ-033 SHALL cover positive saturation at ACC_W=16: 33 beats of 1024 in frames with MAX_TERMS=255, last on beat 33 -> out_acc=32767, out_ovf=1, out_count=33.
REQ-034 SHALL cover negative saturation: 33 beats of -1016, then a +1016 beat (last) -> out_acc=-32768+1016=-31752, out_ovf=1 (sticky).
REQ-035 SHALL cover MAX_TERMS close: MAX_TERMS=15, 15 beats of 1 with in_last=0 -> DONE, out_acc=15, out_count=15; the 16th offered beat is held off with in_ready=0.
REQ-036 SHALL cover backpressure: out_ready=0 for 4 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, with the next frame starting from acc=sext(first beat).
REQ-037 SHALL cover reset mid-frame: rst_n low after 2 beats -> all outputs 0 immediately; the next frame 7 (last) -> out_acc=7, out_count=1.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums a frame of signed 12-bit products from an 8x4
// multiplier into a saturating ACC_W-bit accumulator. A frame closes on a
// beat marked in_last, or on the beat that reaches MAX_TERMS products. The
// result is then held on the outputs until the consumer takes it.
module product_accumulator #(
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [7:0]       out_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [7:0]       MAX_CNT = 8'(MAX_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             live_q;

    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;

    // Sign-extend the product and form the sum one bit wider than the
    // accumulator; the top two bits disagree exactly when the result does
    // not fit, and the top bit then tells which bound to clamp to.
    always_comb begin
        prod_ext = {{(ACC_W-12){in_prod[11]}}, in_prod};
        sum      = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
        if (!sum_ovf) begin
            sum_sat = sum[ACC_W-1:0];
        end else if (sum[ACC_W]) begin
            sum_sat = ACC_MIN;
        end else begin
            sum_sat = ACC_MAX;
        end
    end

    // Frame state machine: load on the first beat, saturating-add on the
    // following beats, and hold the result in DONE until it is taken.
    // in_ready stays low until the first edge after reset is released.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        in_ready = live_q && (state_q != DONE);
        accept   = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = prod_ext;
                    count_d = 8'd1;
                    ovf_d   = 1'b0;
                    state_d = (in_last || (count_d == MAX_CNT)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = sum_sat;
                    count_d = count_q + 8'd1;
                    ovf_d   = ovf_q | sum_ovf;
                    state_d = (in_last || (count_d == MAX_CNT)) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any partial or pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            live_q  <= 1'b1;
        end
    end

    // Result outputs come straight from the registers.
    always_comb begin
        out_valid = (state_q == DONE);
        out_acc   = acc_q;
        out_ovf   = ovf_q;
        out_count = count_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator. Three instances share the input side:
// dut_a (MAX_TERMS=255) carries most scenarios, dut_b (MAX_TERMS=15) the
// term-limit close and dut_c (MAX_TERMS=1) the single-beat frame.
module tb_product_accumulator;

    localparam int ACC_W   = 16;
    localparam int ACC_MAX = 32767;
    localparam int ACC_MIN = -32768;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_prod;
    logic        in_last;
    logic        out_ready;

    logic             a_in_ready, a_out_valid, a_out_ovf;
    logic [ACC_W-1:0] a_out_acc;
    logic [7:0]       a_out_count;
    logic             b_in_ready, b_out_valid, b_out_ovf;
    logic [ACC_W-1:0] b_out_acc;
    logic [7:0]       b_out_count;
    logic             c_in_ready, c_out_valid, c_out_ovf;
    logic [ACC_W-1:0] c_out_acc;
    logic [7:0]       c_out_count;

    int checks   = 0;
    int failures = 0;

    product_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_acc(a_out_acc), .out_ovf(a_out_ovf),
        .out_count(a_out_count)
    );

    product_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_acc(b_out_acc), .out_ovf(b_out_ovf),
        .out_count(b_out_count)
    );

    product_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_acc(c_out_acc), .out_ovf(c_out_ovf),
        .out_count(c_out_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model step: add a product to a running frame sum with clamping.
    function automatic int model_add(input int acc, input int v, output bit sat);
        int s;
        s   = acc + v;
        sat = 1'b0;
        if (s > ACC_MAX) begin s = ACC_MAX; sat = 1'b1; end
        if (s < ACC_MIN) begin s = ACC_MIN; sat = 1'b1; end
        return s;
    endfunction

    // Offer one beat, waiting (bounded) for the chosen instance to be ready.
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input int which, input int v, input logic last);
        int   waited;
        logic rdy;
        waited   = 0;
        in_valid = 1'b1;
        in_prod  = 12'(v);
        in_last  = last;
        forever begin
            rdy = (which == 0) ? a_in_ready : (which == 1) ? b_in_ready : c_in_ready;
            if (rdy) break;
            if (waited >= 50) begin
                checks++;
                failures++;
                $display("[TB] FAIL beat_accept_timeout ready=%0b required=1", rdy);
                break;
            end
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        send_beat(0, 5, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl valid=%0b ready=%0b required=0/0", a_out_valid, a_in_ready);
        end
        checks++;
        if (a_out_acc !== '0 || a_out_count !== 8'd0 || a_out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_data acc=%0d count=%0d ovf=%0b required=0/0/0",
                     a_out_acc, a_out_count, a_out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_before_edge got=%0b required=0", a_in_ready);
        end
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_edge got=%0b required=1", a_in_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_beat(0, 5, 1'b0);
        send_beat(0, -3, 1'b0);
        checks++;
        if (a_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_early_valid got=%0b required=0", a_out_valid);
        end
        send_beat(0, 100, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || $signed(a_out_acc) !== 16'sd102 ||
            a_out_count !== 8'd3 || a_out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_frame valid=%0b acc=%0d count=%0d ovf=%0b required=1/102/3/0",
                     a_out_valid, $signed(a_out_acc), a_out_count, a_out_ovf);
        end
        take_result();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_release valid=%0b ready=%0b required=0/1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_pos_sat();
        int  acc_m;
        bit  ovf_m, s;
        do_reset();
        acc_m = 0;
        ovf_m = 1'b0;
        for (int i = 0; i < 33; i++) begin
            acc_m = (i == 0) ? 1024 : model_add(acc_m, 1024, s);
            if (i != 0) ovf_m = ovf_m | s;
            send_beat(0, 1024, (i == 32));
        end
        checks++;
        if (a_out_valid !== 1'b1 || $signed(a_out_acc) !== 16'(acc_m) || acc_m != 32767 ||
            a_out_ovf !== ovf_m || a_out_count !== 8'd33) begin
            failures++;
            $display("[TB] FAIL pos_sat valid=%0b acc=%0d ovf=%0b count=%0d required=1/%0d/%0b/33",
                     a_out_valid, $signed(a_out_acc), a_out_ovf, a_out_count, acc_m, ovf_m);
        end
        take_result();
    endtask

    task automatic test_neg_sat();
        do_reset();
        for (int i = 0; i < 33; i++) send_beat(0, -1016, 1'b0);
        send_beat(0, 1016, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || $signed(a_out_acc) !== -16'sd31752 ||
            a_out_ovf !== 1'b1 || a_out_count !== 8'd34) begin
            failures++;
            $display("[TB] FAIL neg_sat valid=%0b acc=%0d ovf=%0b count=%0d required=1/-31752/1/34",
                     a_out_valid, $signed(a_out_acc), a_out_ovf, a_out_count);
        end
        take_result();
    endtask

    task automatic test_max_terms();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send_beat(1, 1, 1'b0);
            if (i == 0) begin
                checks++;
                if (c_out_valid !== 1'b1 || c_out_acc !== 16'd1 || c_out_count !== 8'd1) begin
                    failures++;
                    $display("[TB] FAIL single_term valid=%0b acc=%0d count=%0d required=1/1/1",
                             c_out_valid, c_out_acc, c_out_count);
                end
            end
        end
        checks++;
        if (b_out_valid !== 1'b1 || b_out_acc !== 16'd15 || b_out_count !== 8'd15 || b_out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL max_terms valid=%0b acc=%0d count=%0d ovf=%0b required=1/15/15/0",
                     b_out_valid, b_out_acc, b_out_count, b_out_ovf);
        end
        in_valid = 1'b1;
        in_prod  = 12'd1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (b_in_ready !== 1'b0 || b_out_count !== 8'd15 || b_out_acc !== 16'd15) begin
                failures++;
                $display("[TB] FAIL max_terms_hold ready=%0b count=%0d acc=%0d required=0/15/15",
                         b_in_ready, b_out_count, b_out_acc);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int a0, a1, a2;
        do_reset();
        a0 = $urandom_range(0, 4000) - 2000;
        a1 = $urandom_range(0, 4000) - 2000;
        a2 = $urandom_range(0, 4000) - 2000;
        send_beat(0, a0, 1'b0);
        send_beat(0, a1, 1'b0);
        send_beat(0, a2, 1'b1);
        in_valid = 1'b1;
        in_prod  = 12'd77;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || $signed(a_out_acc) !== 16'(a0 + a1 + a2) ||
                a_out_count !== 8'd3 || a_out_ovf !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold valid=%0b ready=%0b acc=%0d count=%0d required=1/0/%0d/3",
                         a_out_valid, a_in_ready, $signed(a_out_acc), a_out_count, a0 + a1 + a2);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_release valid=%0b ready=%0b required=0/1", a_out_valid, a_in_ready);
        end
        send_beat(0, -20, 1'b0);
        send_beat(0, 30, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_acc !== 16'd10 || a_out_count !== 8'd2) begin
            failures++;
            $display("[TB] FAIL bp_next_frame valid=%0b acc=%0d count=%0d required=1/10/2",
                     a_out_valid, $signed(a_out_acc), a_out_count);
        end
        take_result();
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_beat(0, 300, 1'b0);
        send_beat(0, 400, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_out_acc !== '0 ||
            a_out_count !== 8'd0 || a_out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid valid=%0b ready=%0b acc=%0d count=%0d required=0/0/0/0",
                     a_out_valid, a_in_ready, a_out_acc, a_out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(0, 7, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_acc !== 16'd7 || a_out_count !== 8'd1 || a_out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_next valid=%0b acc=%0d count=%0d required=1/7/1",
                     a_out_valid, a_out_acc, a_out_count);
        end
        take_result();
    endtask

    task automatic test_random_frames();
        int  len, v, acc_m, wait_n, mag;
        bit  ovf_m, s, big, neg;
        do_reset();
        for (int f = 0; f < 20; f++) begin
            len   = $urandom_range(1, 40);
            big   = $urandom_range(0, 1);
            neg   = $urandom_range(0, 1);
            acc_m = 0;
            ovf_m = 1'b0;
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (big) begin
                    mag = $urandom_range(1500, 2047);
                    v   = neg ? -mag : mag;
                end else begin
                    v = $urandom_range(0, 4095) - 2048;
                end
                if (b == 0) begin
                    acc_m = v;
                end else begin
                    acc_m = model_add(acc_m, v, s);
                    ovf_m = ovf_m | s;
                end
                send_beat(0, v, (b == len - 1));
            end
            checks++;
            if (a_out_valid !== 1'b1 || $signed(a_out_acc) !== 16'(acc_m) ||
                a_out_ovf !== ovf_m || a_out_count !== 8'(len)) begin
                failures++;
                $display("[TB] FAIL random_frame%0d valid=%0b acc=%0d ovf=%0b count=%0d required=1/%0d/%0b/%0d",
                         f, a_out_valid, $signed(a_out_acc), a_out_ovf, a_out_count, acc_m, ovf_m, len);
            end
            wait_n = $urandom_range(0, 3);
            repeat (wait_n) @(negedge clk);
            take_result();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat();
        test_max_terms();
        test_backpressure();
        test_reset_mid();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
